vga_sync_sequencer: RTL and testbench
=====================================

Name: vga_sync_sequencer

Overview:
- Generates VGA horizontal and vertical timing: pixel/line counters, hsync, vsync and display-enable.
- Each timing flag behaves as a reset-dominant SR flag, set and cleared at programmed counter boundaries.
- Adds a run/stop controller so video only starts and stops on frame boundaries.
- Sits between the pixel-clock-enable source and the pixel/colour datapath.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HCNT_W, 10, hcount width; must hold H_TOTAL-1
- VCNT_W, 10, vcount width; must hold V_TOTAL-1
- SYNC_POL, 0, active sync level (0 = active-low sync)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  pixel enable; counters advance only when en=1
- run  in  1  level request to generate video
- hcount  out  HCNT_W  current pixel column
- vcount  out  VCNT_W  current line
- hsync  out  1  horizontal sync at SYNC_POL level when active
- vsync  out  1  vertical sync at SYNC_POL level when active
- de  out  1  display enable (visible pixel)
- line_start  out  1  one-clk pulse, first clk of hcount=0 in RUN/DRAIN
- frame_start  out  1  one-clk pulse, first clk of (0,0) in RUN/DRAIN
- idle  out  1  1 when state is IDLE

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- If a counter width cannot hold its total-1, raise a simulation error at elaboration.
- All outputs are registered.
- Reset (async, rst_n=0), immediately:
  - state=IDLE, hcount=0, vcount=0
  - hsync=vsync=~SYNC_POL
  - de=0, line_start=0, frame_start=0, idle=1
- FSM states are IDLE, RUN, DRAIN.
- IDLE:
  - counters held at 0, sync outputs inactive, de=0
  - run=1 and en=1 → RUN next clk; counters present (0,0) that clk; frame_start and line_start pulse for that one clk.
- RUN, on each en=1:
  - hcount increments; at H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount wraps to 0 after V_TOTAL-1.
  - en=0 → all counters and flags hold.
- RUN, run=0 → DRAIN on the next clk. Timing continues unchanged in DRAIN.
- DRAIN:
  - On the en=1 clk at (H_TOTAL-1, V_TOTAL-1) → IDLE.
  - Next clk: counters 0, syncs inactive, de=0, idle=1, no frame_start.
  - run=1 again in DRAIN → RUN, with no timing disturbance.
- Flag windows, evaluated against the presented counter values, in the same clk:
  - hsync active iff H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC.
  - vsync active iff V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC, for whole lines.
  - de=1 iff hcount<H_ACTIVE and vcount<V_ACTIVE and state≠IDLE.
- SR semantics:
  - Set at the window start count, reset at the window end count.
  - Reset dominates if both coincide (e.g. a zero-width parameter leaves the flag never active).
  - State is held between events.
- Pulses:
  - line_start/frame_start are high for exactly one clk per counter value.
  - They do not repeat while en=0 holds the counter.
- Reset mid-frame aborts instantly; no partial-frame completion.

Test Plan:
Use small parameters: H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), SYNC_POL=0.
1. Reset: hold rst_n=0 → hcount=0, vcount=0, hsync=vsync=1, de=0, pulses=0, idle=1; release with run=0 → unchanged.
2. run=1, en=1 constant:
   - hsync=0 exactly for hcount 10..12; de=1 for h0-7 on v0-3; vsync=0 for whole lines 5-6.
   - line_start every 14 clks; frame_start every 112 clks.
3. en toggling 1,0,1,0 → counters advance every second clk; line_start/frame_start still one clk wide.
4. Deassert run at (3,2) → frame completes through (13,7); next clk idle=1, counters 0, hsync=vsync=1. Repeat with run re-raised at (5,6) → idle stays 0, next frame_start at (0,0).
5. Assert rst_n=0 asynchronously mid-clock at hcount=11 (hsync=0) → hsync=1, de=0, idle=1 before the next clk edge.
6. SYNC_POL=1 → hsync/vsync idle 0, active 1, windows identical to scenario 2.

Source files
------------

// File: rtl/vga_sync_sequencer.sv
// VGA timing generator: pixel/line counters, SR-style sync and display-enable
// flags, and a run/stop controller that only starts and stops on frame boundaries.
module vga_sync_sequencer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HCNT_W   = 10,
    parameter int VCNT_W   = 10,
    parameter int SYNC_POL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              run,
    output logic [HCNT_W-1:0] hcount,
    output logic [VCNT_W-1:0] vcount,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              line_start,
    output logic              frame_start,
    output logic              idle
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Clear points are taken modulo the total so a zero back porch still
    // terminates the pulse when the counter wraps to 0.
    localparam int HS_SET = H_ACTIVE + H_FP;
    localparam int HS_CLR = (H_ACTIVE + H_FP + H_SYNC) % H_TOTAL;
    localparam int VS_SET = V_ACTIVE + V_FP;
    localparam int VS_CLR = (V_ACTIVE + V_FP + V_SYNC) % V_TOTAL;

    localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(V_TOTAL - 1);

    localparam logic SYNC_ACT  = (SYNC_POL != 0);
    localparam logic SYNC_IDLE = (SYNC_POL == 0);

    if (H_TOTAL - 1 > (2 ** HCNT_W) - 1) begin : g_hcnt_too_narrow
        $error("vga_sync_sequencer: HCNT_W too small for H_TOTAL-1");
    end
    if (V_TOTAL - 1 > (2 ** VCNT_W) - 1) begin : g_vcnt_too_narrow
        $error("vga_sync_sequencer: VCNT_W too small for V_TOTAL-1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [HCNT_W-1:0]   hcount_q, hcount_d;
    logic [VCNT_W-1:0]   vcount_q, vcount_d;
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;
    logic                de_q, de_d;
    logic                line_start_q, line_start_d;
    logic                frame_start_q, frame_start_d;
    logic                idle_q, idle_d;

    logic at_last;
    logic step;
    logic restart;
    logic hs_act;
    logic vs_act;

    always_comb begin
        state_d       = state_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        de_d          = de_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        step          = 1'b0;
        restart       = 1'b0;
        at_last       = (hcount_q == H_LAST) && (vcount_q == V_LAST);
        hs_act        = (hsync_q == SYNC_ACT);
        vs_act        = (vsync_q == SYNC_ACT);

        case (state_q)
            S_IDLE: begin
                if (run && en) begin
                    state_d = S_RUN;
                    restart = 1'b1;
                end
            end
            S_RUN: begin
                step = en;
                if (!run) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // A renewed run request wins over finishing the drain.
                if (run) begin
                    state_d = S_RUN;
                    step    = en;
                end else if (en && at_last) begin
                    state_d = S_IDLE;
                end else begin
                    step = en;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (restart) begin
            hcount_d = '0;
            vcount_d = '0;
        end else if (step) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end

        // Flags are evaluated against the counter value being presented, so a
        // held counter (en=0) holds every flag and suppresses repeat pulses.
        if (restart || step) begin
            if (int'(hcount_d) == HS_CLR)      hs_act = 1'b0;
            else if (int'(hcount_d) == HS_SET) hs_act = 1'b1;
            if (int'(vcount_d) == VS_CLR)      vs_act = 1'b0;
            else if (int'(vcount_d) == VS_SET) vs_act = 1'b1;
            de_d          = (int'(hcount_d) < H_ACTIVE) && (int'(vcount_d) < V_ACTIVE);
            line_start_d  = (hcount_d == '0);
            frame_start_d = (hcount_d == '0) && (vcount_d == '0);
        end

        if (state_d == S_IDLE) begin
            hcount_d      = '0;
            vcount_d      = '0;
            hs_act        = 1'b0;
            vs_act        = 1'b0;
            de_d          = 1'b0;
            line_start_d  = 1'b0;
            frame_start_d = 1'b0;
        end

        hsync_d = hs_act ? SYNC_ACT : SYNC_IDLE;
        vsync_d = vs_act ? SYNC_ACT : SYNC_IDLE;
        idle_d  = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= SYNC_IDLE;
            vsync_q       <= SYNC_IDLE;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            idle_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            idle_q        <= idle_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign idle        = idle_q;

endmodule

// File: tb/tb_vga_sync_sequencer.sv
// Bench for vga_sync_sequencer: two instances (active-low and active-high sync)
// driven in lockstep and compared against a frame-level timing model.
module tb_vga_sync_sequencer;

    localparam int HA = 8, HF = 2, HS = 3, HB = 1;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int HW = 4, VW = 3;

    typedef logic [2*(HW+VW+6)-1:0] vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en    = 1'b0;
    logic run   = 1'b0;

    logic [HW-1:0] hc0, hc1;
    logic [VW-1:0] vc0, vc1;
    logic hs0, vs0, de0, ls0, fs0, id0;
    logic hs1, vs1, de1, ls1, fs1, id1;
    vec_t obs;

    int n_tests = 0;
    int n_fail  = 0;

    bit m_idle, m_drain, m_ls, m_fs;
    int m_h, m_v;

    always #5 clk = ~clk;

    vga_sync_sequencer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HCNT_W(HW), .VCNT_W(VW), .SYNC_POL(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .run(run),
        .hcount(hc0), .vcount(vc0), .hsync(hs0), .vsync(vs0), .de(de0),
        .line_start(ls0), .frame_start(fs0), .idle(id0)
    );

    vga_sync_sequencer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HCNT_W(HW), .VCNT_W(VW), .SYNC_POL(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .run(run),
        .hcount(hc1), .vcount(vc1), .hsync(hs1), .vsync(vs1), .de(de1),
        .line_start(ls1), .frame_start(fs1), .idle(id1)
    );

    assign obs = {hc0, vc0, hs0, vs0, de0, ls0, fs0, id0,
                  hc1, vc1, hs1, vs1, de1, ls1, fs1, id1};

    function automatic void model_reset();
        m_idle  = 1'b1;
        m_drain = 1'b0;
        m_h     = 0;
        m_v     = 0;
        m_ls    = 1'b0;
        m_fs    = 1'b0;
    endfunction

    // One pixel-clock of the frame-level behaviour, given the inputs at the edge.
    function automatic void model_step(bit r, bit e);
        m_ls = 1'b0;
        m_fs = 1'b0;
        if (m_idle) begin
            if (r && e) begin
                m_idle  = 1'b0;
                m_drain = 1'b0;
                m_h     = 0;
                m_v     = 0;
                m_ls    = 1'b1;
                m_fs    = 1'b1;
            end
        end else if (m_drain && !r && e && m_h == HT - 1 && m_v == VT - 1) begin
            model_reset();
        end else begin
            if (e) begin
                m_h = m_h + 1;
                if (m_h == HT) begin
                    m_h = 0;
                    m_v = (m_v + 1) % VT;
                end
                m_ls = (m_h == 0);
                m_fs = (m_h == 0) && (m_v == 0);
            end
            m_drain = !r;
        end
    endfunction

    function automatic vec_t exp_vec();
        bit hsa, vsa, dea;
        hsa = !m_idle && (m_h >= HA + HF) && (m_h < HA + HF + HS);
        vsa = !m_idle && (m_v >= VA + VF) && (m_v < VA + VF + VS);
        dea = !m_idle && (m_h < HA) && (m_v < VA);
        return {HW'(m_h), VW'(m_v), ~hsa, ~vsa, dea, m_ls, m_fs, m_idle,
                HW'(m_h), VW'(m_v), hsa, vsa, dea, m_ls, m_fs, m_idle};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(run, en);
        #1;
    endtask

    task automatic test_reset();
        run = 1'b0;
        en  = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (obs !== exp_vec())
            $display("FAIL reset_async: got %h want %h", obs, exp_vec());
        if (obs !== exp_vec()) n_fail++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        rst_n = 1'b1;
        en    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (obs !== exp_vec() || id0 !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_release cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_run_constant();
        int ls_cnt = 0;
        int fs_cnt = 0;
        run = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            tick();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL run_const cyc %0d: got %h want %h", i, obs, exp_vec());
            end
            ls_cnt += int'(ls0);
            fs_cnt += int'(fs0);
        end
        n_tests++;
        if (ls_cnt != 2 * VT || fs_cnt != 2) begin
            n_fail++;
            $display("FAIL run_const_pulse_count: got ls=%0d fs=%0d want ls=%0d fs=2",
                     ls_cnt, fs_cnt, 2 * VT);
        end
    endtask

    task automatic test_en_toggle();
        run = 1'b1;
        for (int i = 0; i < 4 * HT; i++) begin
            en = (i % 2 == 0);
            tick();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL en_toggle cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
        en = 1'b1;
    endtask

    task automatic test_drain();
        int ph = 0;
        run = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 800 && ph < 5; i++) begin
            tick();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL drain ph %0d cyc %0d: got %h want %h", ph, i, obs, exp_vec());
            end
            case (ph)
                0: if (!m_idle && m_h == 3 && m_v == 2) begin run = 1'b0; ph = 1; end
                1: if (m_idle) begin
                       n_tests++;
                       if (id0 !== 1'b1 || hc0 !== '0 || vc0 !== '0 || hs0 !== 1'b1 || vs0 !== 1'b1) begin
                           n_fail++;
                           $display("FAIL drain_idle: got idle=%b h=%0d v=%0d hs=%b vs=%b want 1 0 0 1 1",
                                    id0, hc0, vc0, hs0, vs0);
                       end
                       run = 1'b1;
                       ph  = 2;
                   end
                2: if (!m_idle && m_h == 3 && m_v == 2) begin run = 1'b0; ph = 3; end
                3: if (m_h == 5 && m_v == 6) begin run = 1'b1; ph = 4; end
                4: if (m_h == 0 && m_v == 0) begin
                       n_tests++;
                       if (id0 !== 1'b0 || fs0 !== 1'b1) begin
                           n_fail++;
                           $display("FAIL drain_rerun: got idle=%b fs=%b want idle=0 fs=1", id0, fs0);
                       end
                       ph = 5;
                   end
                default: ph = 5;
            endcase
        end
        n_tests++;
        if (ph != 5) begin
            n_fail++;
            $display("FAIL drain_timeout: got phase %0d want phase 5", ph);
        end
    endtask

    task automatic test_async_reset();
        bit hit = 1'b0;
        run = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 300 && !hit; i++) begin
            tick();
            if (m_h == 11) hit = 1'b1;
        end
        n_tests++;
        if (!hit || hs0 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_pre: got hit=%b hs=%b want hit=1 hs=0", hit, hs0);
        end
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (obs !== exp_vec() || hs0 !== 1'b1 || de0 !== 1'b0 || id0 !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", obs, exp_vec());
        end
        tick();
        run   = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL async_release cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        run = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) run = ~run;
            en = ($urandom_range(0, 3) != 0);
            tick();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run_constant();
        test_en_toggle();
        test_drain();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
